// File: rtl/usb_packet_framer.sv
// usb_packet_framer: drains the ULPI receive INFO/DATA FIFOs and serialises each packet as
// SYNC, HDR_H, HDR_L, payload[, checksum]. Optional checksum byte: USB_FRAMER_CHECKSUM_EN.
module usb_packet_framer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 clk_ULPI,
    input  logic                 rst,
    input  logic                 INFO_buff_empty,
    input  logic [15:0]          USB_INFO_DATA,
    output logic                 INFO_re,
    input  logic                 DATA_buff_empty,
    input  logic [7:0]           USB_DATA,
    output logic                 DATA_re,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [3:0]           state_dbg
);

    // Handshake: a byte moves on the falling edge where tx_valid && tx_ready are both high;
    // while tx_valid is high and tx_ready low, tx_data and tx_valid hold their values.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INFO_LAT = 4'd1,
        S_SYNC     = 4'd2,
        S_HDR_H    = 4'd3,
        S_HDR_L    = 4'd4,
        S_DATA_RD  = 4'd5,
        S_DATA_LAT = 4'd6,
        S_DATA_TX  = 4'd7,
`ifdef USB_FRAMER_CHECKSUM_EN
        S_CSUM     = 4'd9,
`endif
        S_DONE     = 4'd8
    } state_t;

`ifdef USB_FRAMER_CHECKSUM_EN
    localparam state_t S_LAST = S_CSUM;
`else
    localparam state_t S_LAST = S_DONE;
`endif

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      next_state;
    logic [5:0]  cmd_q;
    logic [9:0]  len_q;
    logic [9:0]  remaining;
    logic [7:0]  data_q;
    logic [7:0]  hdr_h;

    assign hdr_h     = {cmd_q, len_q[9:8]};
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

`ifdef USB_FRAMER_CHECKSUM_EN
    logic [7:0] checksum;

    // Running XOR over everything after SYNC, folded in as each byte is accepted or fetched.
    always_ff @(negedge clk_ULPI or negedge rst) begin
        if (!rst) begin
            checksum <= 8'h00;
        end else begin
            case (state)
                S_INFO_LAT: checksum <= 8'h00;
                S_HDR_H:    if (tx_ready) checksum <= checksum ^ hdr_h;
                S_HDR_L:    if (tx_ready) checksum <= checksum ^ len_q[7:0];
                S_DATA_LAT: checksum <= checksum ^ USB_DATA;
                default:    ;
            endcase
        end
    end
`endif

    always_ff @(negedge clk_ULPI or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cmd_q       <= 6'd0;
            len_q       <= 10'd0;
            remaining   <= 10'd0;
            data_q      <= 8'h00;
            frame_count <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_INFO_LAT: begin
                    cmd_q     <= USB_INFO_DATA[15:10];
                    len_q     <= USB_INFO_DATA[9:0];
                    remaining <= USB_INFO_DATA[9:0];
                end
                S_DATA_LAT: data_q <= USB_DATA;
                S_DATA_TX:  if (tx_ready) remaining <= remaining - 10'd1;
                S_DONE:     frame_count <= frame_count + CNT_ONE;
                default:    ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        INFO_re    = 1'b0;
        DATA_re    = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            S_IDLE: begin
                // Gated by rst so no read strobe leaks out while reset is held.
                if (rst && !INFO_buff_empty) begin
                    INFO_re    = 1'b1;
                    next_state = S_INFO_LAT;
                end
            end
            S_INFO_LAT: next_state = S_SYNC;
            S_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) next_state = S_HDR_H;
            end
            S_HDR_H: begin
                tx_valid = 1'b1;
                tx_data  = hdr_h;
                if (tx_ready) next_state = S_HDR_L;
            end
            S_HDR_L: begin
                tx_valid = 1'b1;
                tx_data  = len_q[7:0];
                if (tx_ready) next_state = (len_q == 10'd0) ? S_LAST : S_DATA_RD;
            end
            S_DATA_RD: begin
                if (!DATA_buff_empty) begin
                    DATA_re    = 1'b1;
                    next_state = S_DATA_LAT;
                end
            end
            S_DATA_LAT: next_state = S_DATA_TX;
            S_DATA_TX: begin
                tx_valid = 1'b1;
                tx_data  = data_q;
                // remaining still holds the pre-decrement count here
                if (tx_ready) next_state = (remaining == 10'd1) ? S_LAST : S_DATA_RD;
            end
`ifdef USB_FRAMER_CHECKSUM_EN
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = checksum;
                if (tx_ready) next_state = S_DONE;
            end
`endif
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_packet_framer.sv
// Directed bench for usb_packet_framer: behavioural INFO/DATA FIFOs with one-cycle read
// latency feed the DUT while a byte scoreboard checks the framed output stream.
module tb_usb_packet_framer;
    localparam int         CW   = 3;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk_ULPI = 1'b0;
    logic          rst = 1'b0;
    logic          INFO_buff_empty = 1'b1;
    logic [15:0]   USB_INFO_DATA = 16'h0;
    logic          INFO_re;
    logic          DATA_buff_empty = 1'b1;
    logic [7:0]    USB_DATA = 8'h0;
    logic          DATA_re;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic [CW-1:0] frame_count;
    logic [3:0]    state_dbg;

    always #8 clk_ULPI = ~clk_ULPI;

    usb_packet_framer #(.SYNC_BYTE(SYNC), .CNT_WIDTH(CW)) dut (
        .clk_ULPI(clk_ULPI), .rst(rst),
        .INFO_buff_empty(INFO_buff_empty), .USB_INFO_DATA(USB_INFO_DATA), .INFO_re(INFO_re),
        .DATA_buff_empty(DATA_buff_empty), .USB_DATA(USB_DATA), .DATA_re(DATA_re),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_count(frame_count), .state_dbg(state_dbg)
    );

    logic [7:0]  exp_q[$];
    logic [15:0] info_fifo[$];
    logic [7:0]  data_fifo[$];
    logic [7:0]  fixed_pl[$];
    int          frame_len_q[$];

    int checks = 0;
    int errors = 0;
    int cur_left = 0;
    int byte_idx = -1;
    int exp_frames = 0;
    int info_re_cnt = 0;
    int data_re_cnt = 0;
    int hold_idx = -1;
    int hold_left = 0;
    int stall_idx = -1;
    int stall_left = 0;
    bit rand_ready = 0;
    logic        info_pend = 1'b0;
    logic        data_pend = 1'b0;
    logic [15:0] info_val = 16'h0;
    logic [7:0]  data_val = 8'h0;
    logic        prev_stalled = 1'b0;
    logic [7:0]  prev_data = 8'h0;
    logic        prev_info_re = 1'b0;
    logic        prev_data_re = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue one packet into the FIFO models and its expected frame into the scoreboard.
    task automatic push_frame(input logic [5:0] cmd, input int len);
        logic [9:0] l10;
        logic [7:0] hh, hl, b, cs;
        l10 = len[9:0];
        hh  = {cmd, l10[9:8]};
        hl  = l10[7:0];
        info_fifo.push_back({cmd, l10});
        exp_q.push_back(SYNC);
        exp_q.push_back(hh);
        exp_q.push_back(hl);
        cs = hh ^ hl;
        for (int i = 0; i < len; i++) begin
            if (fixed_pl.size() > 0) b = fixed_pl.pop_front();
            else b = 8'($urandom_range(0, 255));
            data_fifo.push_back(b);
            exp_q.push_back(b);
            cs = cs ^ b;
        end
`ifdef USB_FRAMER_CHECKSUM_EN
        exp_q.push_back(cs);
        frame_len_q.push_back(len + 4);
`else
        frame_len_q.push_back(len + 3);
`endif
        exp_frames++;
    endtask

    // One clock: drive inputs after the rising edge, observe #1 later, DUT acts on falling edge.
    task automatic cycle();
        logic holding;
        @(posedge clk_ULPI);
        USB_INFO_DATA = info_pend ? info_val : 16'($urandom);
        USB_DATA      = data_pend ? data_val : 8'($urandom);
        info_pend = 1'b0;
        data_pend = 1'b0;
        if (stall_idx >= 0 && byte_idx == stall_idx) begin
            stall_left = 10;
            stall_idx  = -1;
        end
        if (hold_idx >= 0 && byte_idx == hold_idx) begin
            hold_left = 5;
            hold_idx  = -1;
        end
        holding         = (hold_left > 0);
        DATA_buff_empty = (data_fifo.size() == 0) || (stall_left > 0);
        INFO_buff_empty = (info_fifo.size() == 0);
        tx_ready = holding ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
        #1;
        if (stall_left > 0) begin
            check("stall_data_re", 16'(DATA_re), 16'd0);
            check("stall_tx_valid", 16'(tx_valid), 16'd0);
            stall_left--;
        end
        if (holding) begin
            check("bp_tx_valid", 16'(tx_valid), 16'd1);
            check("bp_tx_data", 16'(tx_data), (exp_q.size() > 0) ? 16'(exp_q[0]) : 16'hFFFF);
            hold_left--;
        end
        if (INFO_re) begin
            check("info_re_empty", 16'(INFO_buff_empty), 16'd0);
            check("info_re_mid_frame", 16'(cur_left), 16'd0);
            check("info_re_pulse", 16'(prev_info_re), 16'd0);
            check("info_re_busy", 16'(busy), 16'd0);
            info_val  = (info_fifo.size() > 0) ? info_fifo.pop_front() : 16'($urandom);
            cur_left  = (frame_len_q.size() > 0) ? frame_len_q.pop_front() : 0;
            info_pend = 1'b1;
            byte_idx  = 0;
            info_re_cnt++;
        end
        if (DATA_re) begin
            check("data_re_empty", 16'(DATA_buff_empty), 16'd0);
            check("data_re_pulse", 16'(prev_data_re), 16'd0);
            data_val  = (data_fifo.size() > 0) ? data_fifo.pop_front() : 8'($urandom);
            data_pend = 1'b1;
            data_re_cnt++;
        end
        if (prev_stalled) begin
            check("hold_valid", 16'(tx_valid), 16'd1);
            check("hold_data", 16'(tx_data), 16'(prev_data));
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() > 0) check("tx_byte", 16'(tx_data), 16'(exp_q.pop_front()));
            else check("tx_unexpected", 16'(tx_valid), 16'd0);
            byte_idx++;
            cur_left--;
        end
        prev_stalled = tx_valid && !tx_ready;
        prev_data    = tx_data;
        prev_info_re = INFO_re;
        prev_data_re = DATA_re;
    endtask

    task automatic drain(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (exp_q.size() == 0 && info_fifo.size() == 0 && !info_pend && busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_drain"}, 16'(done), 16'd1);
        check({tag, "_frame_count"}, 16'(frame_count), 16'(exp_frames % (1 << CW)));
        byte_idx = -1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ir0, dr0;
        logic found;

        // Reset state
        repeat (3) @(posedge clk_ULPI);
        #1;
        check("rst_tx_valid", 16'(tx_valid), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_info_re", 16'(INFO_re), 16'd0);
        check("rst_data_re", 16'(DATA_re), 16'd0);
        check("rst_tx_data", 16'(tx_data), 16'd0);
        check("rst_frame_count", 16'(frame_count), 16'd0);
        check("rst_state_idle", 16'(state_dbg), 16'd0);
        rst = 1'b1;
        repeat (2) cycle();

        // Basic 3-byte packet: A5 74 03 11 22 33
        ir0 = info_re_cnt; dr0 = data_re_cnt;
        fixed_pl = '{8'h11, 8'h22, 8'h33};
        push_frame(6'h1D, 3);
        drain("len3", 100);
        check("len3_info_reads", 16'(info_re_cnt - ir0), 16'd1);
        check("len3_data_reads", 16'(data_re_cnt - dr0), 16'd3);

        // LEN==0: header only, no DATA reads
        ir0 = info_re_cnt; dr0 = data_re_cnt;
        push_frame(6'h10, 0);
        drain("len0", 100);
        check("len0_data_reads", 16'(data_re_cnt - dr0), 16'd0);

        // Backpressure held for 5 cycles on HDR_L
        ir0 = info_re_cnt; dr0 = data_re_cnt;
        push_frame(6'h2B, 3);
        hold_idx = 2;
        drain("bp", 100);
        check("bp_info_reads", 16'(info_re_cnt - ir0), 16'd1);
        check("bp_data_reads", 16'(data_re_cnt - dr0), 16'd3);

        // DATA FIFO empty for 10 cycles after first payload byte
        push_frame(6'h05, 3);
        stall_idx = 4;
        drain("stall", 120);

        // Two queued packets back to back
        ir0 = info_re_cnt;
        push_frame(6'h21, 1);
        push_frame(6'h3F, 2);
        drain("b2b", 200);
        check("b2b_info_reads", 16'(info_re_cnt - ir0), 16'd2);

        // Maximum length packet
        push_frame(6'h33, 1023);
        drain("len1023", 4000);

        // Asynchronous reset while a payload byte is on the output
        push_frame(6'h2A, 3);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (byte_idx == 4) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_reset_reached", 16'(found), 16'd1);
        rst = 1'b0;
        #1;
        check("mid_reset_async_valid", 16'(tx_valid), 16'd0);
        @(posedge clk_ULPI);
        #1;
        check("mid_reset_tx_valid", 16'(tx_valid), 16'd0);
        check("mid_reset_busy", 16'(busy), 16'd0);
        check("mid_reset_info_re", 16'(INFO_re), 16'd0);
        check("mid_reset_data_re", 16'(DATA_re), 16'd0);
        check("mid_reset_frame_count", 16'(frame_count), 16'd0);
        exp_q.delete(); data_fifo.delete(); info_fifo.delete(); frame_len_q.delete();
        exp_frames = 0; cur_left = 0; byte_idx = -1;
        info_pend = 1'b0; data_pend = 1'b0;
        prev_stalled = 1'b0; prev_info_re = 1'b0; prev_data_re = 1'b0;
        DATA_buff_empty = 1'b1; INFO_buff_empty = 1'b1;
        @(posedge clk_ULPI);
        #1;
        rst = 1'b1;

        // Random packets with random backpressure; frame_count wraps past 7
        rand_ready = 1;
        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < 3; f++) push_frame(6'($urandom_range(0, 63)), $urandom_range(0, 6));
            drain("rand", 400);
        end
        rand_ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
